// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: opcodes, FSM encoding,
// byte-enable patterns and access-size decode helpers.
package mem_pkg;

  localparam logic [5:0] OPC_LB  = 6'h20;
  localparam logic [5:0] OPC_LH  = 6'h21;
  localparam logic [5:0] OPC_LW  = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24;
  localparam logic [5:0] OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB  = 6'h28;
  localparam logic [5:0] OPC_SH  = 6'h29;
  localparam logic [5:0] OPC_SW  = 6'h2B;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  function automatic acc_size_e opc_size(input logic [5:0] opc);
    case (opc)
      OPC_LB, OPC_LBU, OPC_SB: return SZ_BYTE;
      OPC_LH, OPC_LHU, OPC_SH: return SZ_HALF;
      OPC_LW, OPC_SW:          return SZ_WORD;
      default:                 return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] opc);
    return (opc == OPC_SB) || (opc == OPC_SH) || (opc == OPC_SW);
  endfunction

  // Natural alignment: drop the low address bits that fall inside the access size.
  function automatic logic [1:0] align_off(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return {off[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    return align_off(sz, off) != off;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory valid/ready bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane steering: big-endian byte enables and store replication on the
// store side, lane extraction with sign/zero extension on the load side.
module lsu_align
  import mem_pkg::*;
(
  input  logic [5:0]  st_opc,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [5:0]  ld_opc,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    be    = '0;
    wdata = '0;
    case (opc_size(st_opc))
      SZ_BYTE: begin
        be    = BE_BYTE0 >> st_off;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = st_off[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata = {2{st_data[15:0]}};
      end
      SZ_WORD: begin
        be    = BE_WORD;
        wdata = st_data;
      end
      default: ;
    endcase
    if (!is_store(st_opc)) wdata = '0;
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[31:24];
      2'd1:    ld_byte = rdata[23:16];
      2'd2:    ld_byte = rdata[15:8];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ld_off[1] ? rdata[15:0] : rdata[31:16];
    ld_data = '0;
    case (ld_opc)
      OPC_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      OPC_LBU: ld_data = {24'd0, ld_byte};
      OPC_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      OPC_LHU: ld_data = {16'd0, ld_half};
      OPC_LW:  ld_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: IDLE/ACCESS/DONE FSM, request latches and bus timeout.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opc,
  input  logic [31:0] ea,
  input  logic [31:0] dm_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]       state_q, state_d;
  logic [5:0]       opc_q;
  logic [1:0]       off_q;
  logic             trap_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             trap_now;
  logic [1:0]       off_now;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_data;

  assign off_now = align_off(opc_size(opc), ea[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign trap_now = misaligned(opc_size(opc), ea[1:0]);
  assign misalign = done & trap_q;
`else
  assign trap_now = 1'b0;
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .st_opc  (opc),
    .st_off  (off_now),
    .st_data (dm_in),
    .be      (st_be),
    .wdata   (st_wdata),
    .ld_opc  (opc_q),
    .ld_off  (off_q),
    .rdata   (bus.mem_rdata),
    .ld_data (ld_data)
  );

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (opc_size(opc) == SZ_NONE) ? S_DONE : S_ACCESS;
      // A trapped access passes through ACCESS without a request to keep the 2-cycle latency.
      S_ACCESS: if (trap_q || bus.mem_ready || timeout) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
    if (reset) begin
      state_q       <= S_IDLE;
      opc_q         <= '0;
      off_q         <= '0;
      trap_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      load_data     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          opc_q         <= opc;
          off_q         <= off_now;
          trap_q        <= trap_now;
          err_q         <= 1'b0;
          cnt_q         <= '0;
          load_data     <= '0;
          bus.mem_addr  <= {ea[31:2], 2'b00};
          bus.mem_be    <= trap_now ? 4'b0000 : st_be;
          bus.mem_we    <= is_store(opc) & ~trap_now;
          bus.mem_wdata <= st_wdata;
        end
        S_ACCESS: if (!trap_q) begin
          if (bus.mem_ready) begin
            load_data <= ld_data;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req = (state_q == S_ACCESS) & ~trap_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign bus_err     = done & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized transactions against a
// byte-lane reference model, and hand-written reset / busy corner sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opc;
  logic [31:0] ea, dm_in;
  logic        busy, done, bus_err, misalign;
  logic [31:0] load_data;
  int          total = 0;
  int          bad = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opc       (opc),
    .ea        (ea),
    .dm_in     (dm_in),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int opc_bytes(input logic [5:0] o);
    case (o)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  // Reference: byte i counts from the most significant lane (big-endian).
  function automatic void model(input logic [5:0] o, input logic [31:0] a, d, r,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld, output logic we);
    int sz, off;
    logic [31:0] v, mask;
    sz = opc_bytes(o);
    be = '0; wd = '0; ld = '0;
    we = (o == 6'h28) || (o == 6'h29) || (o == 6'h2B);
    if (sz == 0) return;
    off = (int'(a[1:0]) / sz) * sz;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) be[3-i] = 1'b1;
      wd[8*(3-i) +: 8] = d[8*((3-i) % sz) +: 8];
    end
    if (!we) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      v = (r >> (8*(4 - off - sz))) & mask;
      if ((o == 6'h20 || o == 6'h21) && v[8*sz-1]) v = v | ~mask;
      ld = v;
    end
  endfunction

  // One transaction; dly < 0 means mem_ready is never given.
  task automatic run_txn(input logic [5:0] o, input logic [31:0] a, d, r, input int dly,
                         output int done_cyc, output int req_cnt,
                         output logic [31:0] addr, output logic [3:0] be, output logic we,
                         output logic [31:0] wd, output logic [31:0] ld, output logic err,
                         output logic busy_ok, output logic stable);
    done_cyc = -1; req_cnt = 0; busy_ok = 1'b1; stable = 1'b1;
    addr = '0; be = '0; we = 1'b0; wd = '0; ld = '0; err = 1'b0;
    @(negedge clk);
    start = 1'b1; opc = o; ea = a; dm_in = d; bus.mem_rdata = r;
    @(posedge clk); #1;
    start = 1'b0; opc = 6'($urandom); ea = $urandom; dm_in = $urandom;
    for (int c = 1; c <= 40; c++) begin
      bus.mem_ready = (dly >= 0) && (c == 1 + dly);
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (bus.mem_req) begin
        if (req_cnt == 0) begin
          addr = bus.mem_addr; be = bus.mem_be; we = bus.mem_we; wd = bus.mem_wdata;
        end else if (addr !== bus.mem_addr || be !== bus.mem_be || we !== bus.mem_we ||
                     wd !== bus.mem_wdata) begin
          stable = 1'b0;
        end
        req_cnt++;
      end
      if (done) begin
        done_cyc = c; ld = load_data; err = bus_err;
        break;
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    if (busy || done) busy_ok = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] ea, dm, rd;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_load;
    int          e_done;
    logic        e_err;
    int          e_req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          dc, rc;
    logic [31:0] a_o, wd_o, ld_o;
    logic [3:0]  be_o;
    logic        we_o, err_o, bok, stb;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    logic        ewe;
    logic [5:0]  ro;
    logic [31:0] ra, rd_v, rr;
    int          rdly;
    logic        saw_done;
    logic [5:0]  opcs[9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0F};

    //            opc    ea             dm             rd             dly addr           be       we    wdata          load           done err req
    vecs[0] = '{6'h2B, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_0100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0,         2,  1'b0, 1};
    vecs[1] = '{6'h20, 32'h0000_0203, 32'h0,         32'h1122_33F0, 0, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,         32'hFFFF_FFF0, 2,  1'b0, 1};
    vecs[2] = '{6'h24, 32'h0000_0203, 32'h0,         32'h1122_33F0, 0, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,         32'h0000_00F0, 2,  1'b0, 1};
    vecs[3] = '{6'h21, 32'h0000_0202, 32'h0,         32'h1234_ABCD, 3, 32'h0000_0200, 4'b0011, 1'b0, 32'h0,         32'hFFFF_ABCD, 5,  1'b0, 4};
    vecs[4] = '{6'h28, 32'h0000_0101, 32'h0000_00A5, 32'h0,         0, 32'h0000_0100, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0,         2,  1'b0, 1};
    vecs[5] = '{6'h23, 32'h0000_0102, 32'h0,         32'hCAFE_F00D, 1, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,         32'hCAFE_F00D, 3,  1'b0, 2};
    vecs[6] = '{6'h25, 32'h0000_0200, 32'h0,         32'h8001_7FFF, 0, 32'h0000_0200, 4'b1100, 1'b0, 32'h0,         32'h0000_8001, 2,  1'b0, 1};
    vecs[7] = '{6'h29, 32'h0000_0306, 32'h1234_BEEF, 32'h0,         2, 32'h0000_0304, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0,         4,  1'b0, 3};
    vecs[8] = '{6'h00, 32'h0000_0044, 32'h0,         32'h5555_5555, 0, 32'h0,         4'b0000, 1'b0, 32'h0,         32'h0,         1,  1'b0, 0};
    vecs[9] = '{6'h23, 32'h0000_0400, 32'h0,         32'h7777_7777,-1, 32'h0000_0400, 4'b1111, 1'b0, 32'h0,         32'h0,         17, 1'b1, 16};

    reset = 1'b1; start = 1'b0; opc = '0; ea = '0; dm_in = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset bus_err", {31'd0, bus_err}, 32'd0);
    check("reset misalign", {31'd0, misalign}, 32'd0);
    check("reset load_data", load_data, 32'd0);
    check("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'd0);
    check("reset mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mem_ready while idle must not start or finish anything
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle ready done", {31'd0, done}, 32'd0);
    check("idle ready busy", {31'd0, busy}, 32'd0);
    bus.mem_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].opc, vecs[i].ea, vecs[i].dm, vecs[i].rd, vecs[i].dly,
              dc, rc, a_o, be_o, we_o, wd_o, ld_o, err_o, bok, stb);
      check($sformatf("vec%0d done_cycle", i), dc, vecs[i].e_done);
      check($sformatf("vec%0d req_cycles", i), rc, vecs[i].e_req);
      check($sformatf("vec%0d load_data", i), ld_o, vecs[i].e_load);
      check($sformatf("vec%0d bus_err", i), {31'd0, err_o}, {31'd0, vecs[i].e_err});
      check($sformatf("vec%0d busy", i), {31'd0, bok}, 32'd1);
      check($sformatf("vec%0d stable", i), {31'd0, stb}, 32'd1);
      if (vecs[i].e_req > 0) begin
        check($sformatf("vec%0d addr", i), a_o, vecs[i].e_addr);
        check($sformatf("vec%0d be", i), {28'd0, be_o}, {28'd0, vecs[i].e_be});
        check($sformatf("vec%0d we", i), {31'd0, we_o}, {31'd0, vecs[i].e_we});
        if (vecs[i].e_we) check($sformatf("vec%0d wdata", i), wd_o, vecs[i].e_wdata);
      end
      if (i == 3) begin
        repeat (3) @(negedge clk);
        check("load_data hold", load_data, 32'hFFFF_ABCD);
      end
    end

    for (int n = 0; n < 40; n++) begin
      ro = opcs[$urandom_range(0, 8)];
      ra = $urandom; rd_v = $urandom; rr = $urandom;
      rdly = $urandom_range(0, 4);
      model(ro, ra, rd_v, rr, ebe, ewd, eld, ewe);
      run_txn(ro, ra, rd_v, rr, rdly, dc, rc, a_o, be_o, we_o, wd_o, ld_o, err_o, bok, stb);
      if (opc_bytes(ro) == 0) begin
        check($sformatf("rnd%0d nonmem done", n), dc, 1);
        check($sformatf("rnd%0d nonmem req", n), rc, 0);
        check($sformatf("rnd%0d nonmem load", n), ld_o, 32'd0);
      end else begin
        check($sformatf("rnd%0d done_cycle", n), dc, 2 + rdly);
        check($sformatf("rnd%0d req_cycles", n), rc, rdly + 1);
        check($sformatf("rnd%0d addr", n), a_o, {ra[31:2], 2'b00});
        check($sformatf("rnd%0d be", n), {28'd0, be_o}, {28'd0, ebe});
        check($sformatf("rnd%0d we", n), {31'd0, we_o}, {31'd0, ewe});
        if (ewe) check($sformatf("rnd%0d wdata", n), wd_o, ewd);
        check($sformatf("rnd%0d load", n), ld_o, eld);
        check($sformatf("rnd%0d bus_err", n), {31'd0, err_o}, 32'd0);
        check($sformatf("rnd%0d stable", n), {31'd0, stb}, 32'd1);
      end
      check($sformatf("rnd%0d busy", n), {31'd0, bok}, 32'd1);
    end

    // start held high while busy, with changing inputs: must be ignored
    @(negedge clk);
    start = 1'b1; opc = 6'h23; ea = 32'h0000_0600; bus.mem_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    ea = 32'h0000_0700; opc = 6'h28;
    @(negedge clk);
    check("busy-start addr", bus.mem_addr, 32'h0000_0600);
    check("busy-start we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("busy-start not done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    check("busy-start done", {31'd0, done}, 32'd1);
    check("busy-start load", load_data, 32'h0BAD_F00D);
    @(negedge clk);
    check("busy-start idle", {31'd0, busy}, 32'd0);

    // reset mid-ACCESS, coinciding with mem_ready: reset wins, no done
    @(negedge clk);
    start = 1'b1; opc = 6'h23; ea = 32'h0000_0500; bus.mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rst-mid req before", {31'd0, bus.mem_req}, 32'd1);
    reset = 1'b1; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rst-mid mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst-mid busy", {31'd0, busy}, 32'd0);
    check("rst-mid done", {31'd0, done}, 32'd0);
    check("rst-mid mem_addr", bus.mem_addr, 32'd0);
    check("rst-mid mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst-mid load_data", load_data, 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst-mid no late done", {31'd0, saw_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit. It sits between the execute stage and data memory, consuming the effective address `ea`, store data `dm_in` and the instruction opcode. It runs one MIPS byte, halfword or word load/store per request over a valid/ready memory handshake and returns aligned, sign- or zero-extended load data. Its busy output stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles `mem_req` waits for `mem_ready` before aborting with `bus_err`.

Ports:
- clk  in  1  rising-edge clock; only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid from execute; sampled in IDLE only.
- opc  in  6  MIPS opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
- ea  in  32  byte effective address.
- dm_in  in  32  store data, right-justified.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while done=1, held until the next start.
- bus_err  out  1  one-cycle pulse coincident with done on timeout.
- misalign  out  1  pulse coincident with done (only with MISALIGN_TRAP_EN).
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {ea[31:2],2'b00}.
- mem_be  out  4  byte enables, bit 3 = bits 31:24.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts and completes the request this cycle; read data valid the same cycle.
- mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on start with a load/store opc, latch opc, ea[1:0] and dm_in, drive the memory outputs, and go to ACCESS. A non-memory opc causes no access: go to DONE with load_data=0.
- ACCESS: mem_req=1 with stable addr/be/we/wdata. On mem_ready, capture the aligned read data and go to DONE. If the timeout counter reaches TIMEOUT_CYCLES-1 without mem_ready, drop mem_req and go to DONE with bus_err, and load_data=0.
- DONE: pulse done, then return to IDLE.
- Byte order is big-endian. Byte at ea[1:0]=0 is lane 31:24, giving be 1000/0100/0010/0001. Halfword at ea[1]=0 uses be 1100, else 0011. A word uses be 1111.
- Stores replicate data across lanes: sb {4{b}}, sh {2{h}}, sw the word.
- Loads extract the addressed lane. lb/lh sign-extend; lbu/lhu zero-extend.
- start while busy is ignored; the team's pipeline must hold it.
- mem_ready outside ACCESS is ignored.

## Timing
- Accepted start at cycle 0. mem_req rises at cycle 1.
- mem_ready at cycle 1+k leads to done at cycle 2+k. Minimum latency is 2 cycles.
- busy is high in ACCESS and DONE. It is low in IDLE.
- Reset values: state IDLE, and every output 0, including load_data and mem_addr.
- Reset mid-ACCESS drops mem_req at the next edge. There is no done pulse.
- Reset and mem_ready in the same cycle: reset wins.
- The timeout counter clears on entering ACCESS and saturates, so it never wraps.

## Configuration
- MISALIGN_TRAP_EN defined:
  - An lh/lhu/sh with ea[0]=1, or an lw/sw with ea[1:0]≠0, issues no memory access.
  - The unit goes to DONE with misalign=1 and load_data=0.
  - Latency is 2 cycles.
- Undefined:
  - misalign is tied 0.
  - The offending low address bits are forced to 0, giving natural alignment, and the access proceeds.

## Structure
- Package mem_pkg: opcode localparams, state encoding, byte-enable patterns, TIMEOUT default.
- Sub-module lsu_align, combinational:
  - Store side: (opc, ea[1:0], dm_in) -> (mem_be, mem_wdata).
  - Load side: (opc, ea[1:0], mem_rdata) -> load_data.
- mem_access_unit holds the FSM, latches and timeout counter.

## Test plan
- sw ea=0x100 dm_in=0xDEADBEEF, mem_ready on first request cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, done at cycle 2.
- lb ea=0x203, mem_rdata=0x112233F0 -> be 0001, load_data 0xFFFFFFF0; lbu same -> 0x000000F0.
- lh ea=0x202, mem_rdata=0x1234ABCD, mem_ready delayed 3 cycles -> load_data 0xFFFFABCD, done at cycle 5, busy high cycles 1–5.
- sb ea=0x101 dm_in=0x000000A5 -> be 0100, wdata 0xA5A5A5A5.
- mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_req drops, done+bus_err pulse, load_data 0.
- lw ea=0x102: with MISALIGN_TRAP_EN -> no mem_req, misalign+done at cycle 2. Without it -> mem_addr 0x100, normal load. Reset asserted mid-ACCESS -> all outputs 0 next cycle, no done.
